// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer feeding the architectural
// register file retire write port. Entries are allocated in program order
// at the tail, completed out of order by tag, and retired from the head one
// per cycle once done. A flush drops every in-flight entry.

// One buffer slot. The top level guarantees that alloc_en and complete_en
// never target the same slot in the same cycle, and that retire_en only
// hits a valid, done slot.
module rob_entry #(
    parameter int NUM_REG_LOG2 = 5,
    parameter int REG_SIZE     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_en,
    input  logic [NUM_REG_LOG2-1:0] alloc_rd,
    input  logic                    complete_en,
    input  logic [REG_SIZE-1:0]     complete_data,
    input  logic                    retire_en,
    output logic                    valid,
    output logic                    done,
    output logic [NUM_REG_LOG2-1:0] rd,
    output logic [REG_SIZE-1:0]     data
);

    // Slot state: reset wipes everything, flush only drops valid/done,
    // retire wins over a same-cycle completion to the head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            done  <= 1'b0;
            rd    <= '0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (alloc_en) begin
                valid <= 1'b1;
                done  <= 1'b0;
                rd    <= alloc_rd;
            end
            if (complete_en) begin
                done <= 1'b1;
                data <= complete_data;
            end
            if (retire_en) begin
                valid <= 1'b0;
                done  <= 1'b0;
            end
        end
    end

endmodule

module reorder_buffer #(
    parameter int NUM_ROB      = 16,
    parameter int NUM_ROB_LOG2 = $clog2(NUM_ROB),
    parameter int NUM_REG      = 32,
    parameter int NUM_REG_LOG2 = $clog2(NUM_REG),
    parameter int REG_SIZE     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [NUM_REG_LOG2-1:0] alloc_rd,
    output logic                    alloc_ready,
    output logic [NUM_ROB_LOG2-1:0] alloc_tag,
    input  logic                    complete_valid,
    input  logic [NUM_ROB_LOG2-1:0] complete_tag,
    input  logic [REG_SIZE-1:0]     complete_data,
    input  logic                    flush,
    output logic                    retire_valid,
    output logic [NUM_REG_LOG2-1:0] retire_reg,
    output logic [REG_SIZE-1:0]     retire_reg_data,
    output logic [NUM_ROB_LOG2-1:0] retire_tag,
    output logic [NUM_ROB_LOG2:0]   count
);

    localparam logic [NUM_ROB_LOG2:0]   CNT_FULL = (NUM_ROB_LOG2+1)'(NUM_ROB);
    localparam logic [NUM_ROB_LOG2:0]   CNT_ONE  = (NUM_ROB_LOG2+1)'(1);
    localparam logic [NUM_ROB_LOG2-1:0] PTR_ONE  = NUM_ROB_LOG2'(1);

    // Fields of the slot currently at the head, as seen by the retire port.
    typedef struct packed {
        logic [NUM_REG_LOG2-1:0] rd;
        logic [REG_SIZE-1:0]     data;
    } head_t;

    logic [NUM_ROB_LOG2-1:0] head;
    logic [NUM_ROB_LOG2-1:0] tail;

    logic [NUM_ROB-1:0]                   ent_valid;
    logic [NUM_ROB-1:0]                   ent_done;
    logic [NUM_ROB-1:0][NUM_REG_LOG2-1:0] ent_rd;
    logic [NUM_ROB-1:0][REG_SIZE-1:0]     ent_data;

    logic [NUM_ROB-1:0] alloc_en;
    logic [NUM_ROB-1:0] complete_en;
    logic [NUM_ROB-1:0] retire_en;

    logic  alloc_fire;
    logic  retire_fire;
    logic  nonempty;
    head_t head_view;

    // Full is judged on the registered count only; a retirement in the same
    // cycle does not open a slot until the next cycle.
    assign alloc_ready = (count != CNT_FULL);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_tag   = tail;

    assign retire_valid = ent_valid[head] & ent_done[head] & ~flush;
    assign retire_fire  = retire_valid;
    assign retire_tag   = head;

    // Head fields go out only while something is in flight, so stale rd/data
    // left behind by a flush never appears on the retire port.
    assign nonempty  = (count != '0);
    assign head_view = nonempty ? head_t'{rd: ent_rd[head], data: ent_data[head]} : '0;
    assign retire_reg      = head_view.rd;
    assign retire_reg_data = head_view.data;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ROB; gi++) begin : g_ent
            // A completion only lands on a slot that is already valid, which
            // also rules out hitting the slot being allocated this cycle.
            assign alloc_en[gi]    = alloc_fire  && (tail == NUM_ROB_LOG2'(gi));
            assign complete_en[gi] = complete_valid && ent_valid[gi]
                                     && (complete_tag == NUM_ROB_LOG2'(gi));
            assign retire_en[gi]   = retire_fire && (head == NUM_ROB_LOG2'(gi));

            rob_entry #(
                .NUM_REG_LOG2 (NUM_REG_LOG2),
                .REG_SIZE     (REG_SIZE)
            ) u_ent (
                .clk           (clk),
                .rst           (rst),
                .flush         (flush),
                .alloc_en      (alloc_en[gi]),
                .alloc_rd      (alloc_rd),
                .complete_en   (complete_en[gi]),
                .complete_data (complete_data),
                .retire_en     (retire_en[gi]),
                .valid         (ent_valid[gi]),
                .done          (ent_done[gi]),
                .rd            (ent_rd[gi]),
                .data          (ent_data[gi])
            );
        end
    endgenerate

    // Pointers and occupancy; pointers wrap naturally at NUM_ROB (power of two).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)
                tail <= tail + PTR_ONE;
            if (retire_fire)
                head <= head + PTR_ONE;
            case ({alloc_fire, retire_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule
